// File: rtl/branch_csr_if.sv
// Bundle of branch/CSR signals exchanged between the core datapath and branch_csr_unit.
// The master side drives instruction fields and operands; the slave side returns ben/csr_out/csr_wdata.
interface branch_csr_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] csr_addr;
    logic              csr_wen;
    logic              is_ecall;
    logic              is_mret;
    logic              ben;
    logic [DATA_W-1:0] csr_out;
    logic [DATA_W-1:0] csr_wdata;

    modport master (
        output opcode, func3, src1, src2, pc, csr_addr, csr_wen, is_ecall, is_mret,
        input  ben, csr_out, csr_wdata
    );

    modport slave (
        input  opcode, func3, src1, src2, pc, csr_addr, csr_wen, is_ecall, is_mret,
        output ben, csr_out, csr_wdata
    );
endinterface

// File: rtl/branch_csr_unit.sv
// Branch-condition evaluator and machine-mode CSR file with read-modify-write ALU.
// Outputs are combinational; CSR state changes only on the rising clock edge.
module branch_csr_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    branch_csr_if.slave   bus
);
    localparam logic [6:0]        OP_BRANCH      = 7'b1100011;
    localparam logic [ADDR_W-1:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [ADDR_W-1:0] ADDR_MTVEC     = 12'h305;
    localparam logic [ADDR_W-1:0] ADDR_MEPC      = 12'h341;
    localparam logic [ADDR_W-1:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [ADDR_W-1:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [ADDR_W-1:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [DATA_W-1:0] MSTATUS_RST    = 32'h0000_1800;
    localparam logic [DATA_W-1:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [DATA_W-1:0] CAUSE_ECALL_M  = 32'd11;

    logic [DATA_W-1:0] mstatus_r;
    logic [DATA_W-1:0] mtvec_r;
    logic [DATA_W-1:0] mepc_r;
    logic [DATA_W-1:0] mcause_r;
    logic              ben_s;
    logic [DATA_W-1:0] csr_read_s;
    logic [DATA_W-1:0] csr_out_s;
    logic [DATA_W-1:0] csr_wdata_s;

    // Conditional-branch decision from funct3
    always_comb begin
        ben_s = 1'b0;
        if (bus.opcode == OP_BRANCH) begin
            case (bus.func3)
                3'b000:  ben_s = (bus.src1 == bus.src2);
                3'b001:  ben_s = (bus.src1 != bus.src2);
                3'b100:  ben_s = ($signed(bus.src1) <  $signed(bus.src2));
                3'b101:  ben_s = ($signed(bus.src1) >= $signed(bus.src2));
                3'b110:  ben_s = (bus.src1 <  bus.src2);
                3'b111:  ben_s = (bus.src1 >= bus.src2);
                default: ben_s = 1'b0;
            endcase
        end else begin
            ben_s = 1'b0;
        end
    end

    // CSR read mux; unimplemented addresses read as zero
    always_comb begin
        csr_read_s = {DATA_W{1'b0}};
        case (bus.csr_addr)
            ADDR_MSTATUS:   csr_read_s = mstatus_r;
            ADDR_MTVEC:     csr_read_s = mtvec_r;
            ADDR_MEPC:      csr_read_s = mepc_r;
            ADDR_MCAUSE:    csr_read_s = mcause_r;
            ADDR_MVENDORID: csr_read_s = MVENDORID_VAL;
            ADDR_MARCHID:   csr_read_s = {DATA_W{1'b0}};
            default:        csr_read_s = {DATA_W{1'b0}};
        endcase
    end

    // Trap/return target overrides the addressed CSR so the next-PC mux sees it immediately
    always_comb begin
        csr_out_s = csr_read_s;
        if (bus.is_ecall) begin
            csr_out_s = mtvec_r;
        end else if (bus.is_mret) begin
            csr_out_s = mepc_r;
        end else begin
            csr_out_s = csr_read_s;
        end
    end

    // Read-modify-write ALU; non-CSR funct3 values pass the old value through
    always_comb begin
        csr_wdata_s = csr_out_s;
        case (bus.func3)
            3'b001:  csr_wdata_s = bus.src1;
            3'b010:  csr_wdata_s = csr_out_s | bus.src1;
            3'b011:  csr_wdata_s = csr_out_s & ~bus.src1;
            default: csr_wdata_s = csr_out_s;
        endcase
    end

    // CSR state update: reset, then trap entry, then mret (no change), then explicit write
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= {DATA_W{1'b0}};
            mepc_r    <= {DATA_W{1'b0}};
            mcause_r  <= {DATA_W{1'b0}};
        end else if (bus.is_ecall) begin
            mepc_r   <= bus.pc;
            mcause_r <= CAUSE_ECALL_M;
        end else if (bus.is_mret) begin
            mepc_r <= mepc_r;
        end else if (bus.csr_wen) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: mstatus_r <= csr_wdata_s;
                ADDR_MTVEC:   mtvec_r   <= csr_wdata_s;
                ADDR_MEPC:    mepc_r    <= csr_wdata_s;
                ADDR_MCAUSE:  mcause_r  <= csr_wdata_s;
                default:      mstatus_r <= mstatus_r;
            endcase
        end else begin
            mstatus_r <= mstatus_r;
        end
    end

    assign bus.ben       = ben_s;
    assign bus.csr_out   = csr_out_s;
    assign bus.csr_wdata = csr_wdata_s;
endmodule

// File: tb/tb_branch_csr_unit.sv
// Directed-vector bench for branch_csr_unit: inputs change after the falling edge,
// combinational outputs are checked mid-phase, and CSR state commits at the next rising edge.
module tb_branch_csr_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    branch_csr_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    branch_csr_unit #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] pcv, input logic [11:0] addr,
                         input logic wen, input logic ecall, input logic mret);
        @(negedge clk);
        bus.opcode = op;  bus.func3 = f3;  bus.src1 = s1;  bus.src2 = s2;  bus.pc = pcv;
        bus.csr_addr = addr;  bus.csr_wen = wen;  bus.is_ecall = ecall;  bus.is_mret = mret;
        #1;
    endtask

    task automatic read_csr(input logic [11:0] addr);
        drive(7'h00, 3'b000, 32'h0, 32'h0, 32'h0, addr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h123, 12'hF11, 12'hF12};
        logic [31:0] exps  [7] = '{32'h0000_1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7973_7978, 32'h0};
        rst = 1'b1;
        read_csr(12'h300);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            read_csr(addrs[i]);
            vectors++;
            if (bus.csr_out !== exps[i]) begin
                miscompares++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], bus.csr_out, exps[i]);
            end
        end
    endtask

    task automatic test_branch;
        logic [6:0]  ops [9] = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b0110011, 7'b1100011,
                                 7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};
        logic [2:0]  f3s [9] = '{3'b100, 3'b110, 3'b000, 3'b100, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};
        logic [31:0] s1s [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] s2s [9] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd5, 32'd1, 32'd1, 32'd5, 32'd5};
        logic        exps[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(ops[i], f3s[i], s1s[i], s2s[i], 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (bus.ben !== exps[i]) begin
                miscompares++;
                $display("FAIL branch_%0d f3=%b got=%b exp=%b", i, f3s[i], bus.ben, exps[i]);
            end
        end
    endtask

    task automatic test_csrrw;
        drive(7'b1110011, 3'b001, 32'h8000_0100, 32'h0, 32'h0, 12'h305, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.csr_out !== 32'h0) begin
            miscompares++;
            $display("FAIL csrrw_old got=%h exp=%h", bus.csr_out, 32'h0);
        end
        vectors++;
        if (bus.csr_wdata !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL csrrw_wdata got=%h exp=%h", bus.csr_wdata, 32'h8000_0100);
        end
        read_csr(12'h305);
        vectors++;
        if (bus.csr_out !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL csrrw_new got=%h exp=%h", bus.csr_out, 32'h8000_0100);
        end
    endtask

    task automatic test_csrrs_csrrc;
        drive(7'b1110011, 3'b010, 32'h8, 32'h0, 32'h0, 12'h300, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.csr_out !== 32'h1800 || bus.csr_wdata !== 32'h1808) begin
            miscompares++;
            $display("FAIL csrrs out=%h wdata=%h exp=00001800/00001808", bus.csr_out, bus.csr_wdata);
        end
        drive(7'b1110011, 3'b011, 32'h800, 32'h0, 32'h0, 12'h300, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.csr_out !== 32'h1808 || bus.csr_wdata !== 32'h1008) begin
            miscompares++;
            $display("FAIL csrrc out=%h wdata=%h exp=00001808/00001008", bus.csr_out, bus.csr_wdata);
        end
        read_csr(12'h300);
        vectors++;
        if (bus.csr_out !== 32'h1008) begin
            miscompares++;
            $display("FAIL csrrc_commit got=%h exp=%h", bus.csr_out, 32'h1008);
        end
    endtask

    task automatic test_ecall;
        drive(7'b1110011, 3'b000, 32'h0, 32'h0, 32'h8000_0040, 12'h300, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.csr_out !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL ecall_target got=%h exp=%h", bus.csr_out, 32'h8000_0100);
        end
        read_csr(12'h341);
        vectors++;
        if (bus.csr_out !== 32'h8000_0040) begin
            miscompares++;
            $display("FAIL ecall_mepc got=%h exp=%h", bus.csr_out, 32'h8000_0040);
        end
        read_csr(12'h342);
        vectors++;
        if (bus.csr_out !== 32'd11) begin
            miscompares++;
            $display("FAIL ecall_mcause got=%h exp=%h", bus.csr_out, 32'd11);
        end
        read_csr(12'h300);
        vectors++;
        if (bus.csr_out !== 32'h1008) begin
            miscompares++;
            $display("FAIL ecall_mstatus got=%h exp=%h", bus.csr_out, 32'h1008);
        end
    endtask

    task automatic test_mret;
        drive(7'b1110011, 3'b000, 32'h0, 32'h0, 32'h0, 12'h305, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.csr_out !== 32'h8000_0040) begin
            miscompares++;
            $display("FAIL mret_target got=%h exp=%h", bus.csr_out, 32'h8000_0040);
        end
    endtask

    task automatic test_write_suppression;
        // csrrw to mtvec alongside ecall: mtvec kept, mepc takes the new pc
        drive(7'b1110011, 3'b001, 32'hDEAD_BEEF, 32'h0, 32'h8000_0080, 12'h305, 1'b1, 1'b1, 1'b0);
        read_csr(12'h305);
        vectors++;
        if (bus.csr_out !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL wen_ecall_mtvec got=%h exp=%h", bus.csr_out, 32'h8000_0100);
        end
        read_csr(12'h341);
        vectors++;
        if (bus.csr_out !== 32'h8000_0080) begin
            miscompares++;
            $display("FAIL wen_ecall_mepc got=%h exp=%h", bus.csr_out, 32'h8000_0080);
        end
        drive(7'b1110011, 3'b001, 32'h55, 32'h0, 32'h0, 12'h342, 1'b1, 1'b0, 1'b1);
        read_csr(12'h342);
        vectors++;
        if (bus.csr_out !== 32'd11) begin
            miscompares++;
            $display("FAIL wen_mret_mcause got=%h exp=%h", bus.csr_out, 32'd11);
        end
        drive(7'b1110011, 3'b001, 32'h0, 32'h0, 32'h0, 12'hF11, 1'b1, 1'b0, 1'b0);
        read_csr(12'hF11);
        vectors++;
        if (bus.csr_out !== 32'h7973_7978) begin
            miscompares++;
            $display("FAIL mvendorid_ro got=%h exp=%h", bus.csr_out, 32'h7973_7978);
        end
        drive(7'b1110011, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 12'h123, 1'b1, 1'b0, 1'b0);
        read_csr(12'h123);
        vectors++;
        if (bus.csr_out !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_ro got=%h exp=%h", bus.csr_out, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        drive(7'b1110011, 3'b001, 32'hA5A5_0000, 32'h0, 32'h0, 12'h341, 1'b1, 1'b0, 1'b0);
        drive(7'b1110011, 3'b010, 32'h0000_00F0, 32'h0, 32'h0, 12'h342, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.csr_out !== 32'd11 || bus.csr_wdata !== 32'h0000_00FB) begin
            miscompares++;
            $display("FAIL b2b_rmw out=%h wdata=%h exp=0000000b/000000fb", bus.csr_out, bus.csr_wdata);
        end
        read_csr(12'h341);
        vectors++;
        if (bus.csr_out !== 32'hA5A5_0000) begin
            miscompares++;
            $display("FAIL b2b_mepc got=%h exp=%h", bus.csr_out, 32'hA5A5_0000);
        end
        read_csr(12'h342);
        vectors++;
        if (bus.csr_out !== 32'h0000_00FB) begin
            miscompares++;
            $display("FAIL b2b_mcause got=%h exp=%h", bus.csr_out, 32'h0000_00FB);
        end
    endtask

    task automatic test_reset_priority;
        logic [11:0] addrs [4] = '{12'h300, 12'h305, 12'h341, 12'h342};
        logic [31:0] exps  [4] = '{32'h0000_1800, 32'h0, 32'h0, 32'h0};
        // ecall with a branch opcode while rst is high: ben must still follow its inputs
        drive(7'b1100011, 3'b001, 32'd3, 32'd4, 32'h1234_5678, 12'h300, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.ben !== 1'b1) begin
            miscompares++;
            $display("FAIL ben_in_reset got=%b exp=%b", bus.ben, 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_csr(addrs[i]);
            vectors++;
            if (bus.csr_out !== exps[i]) begin
                miscompares++;
                $display("FAIL rst_ecall addr=%h got=%h exp=%h", addrs[i], bus.csr_out, exps[i]);
            end
        end
    endtask

    initial begin
        bus.opcode = 7'h00;  bus.func3 = 3'b000;  bus.src1 = 32'h0;  bus.src2 = 32'h0;
        bus.pc = 32'h0;  bus.csr_addr = 12'h000;  bus.csr_wen = 1'b0;
        bus.is_ecall = 1'b0;  bus.is_mret = 1'b0;
        test_reset();
        test_branch();
        test_csrrw();
        test_csrrs_csrrc();
        test_ecall();
        test_mret();
        test_write_suppression();
        test_back_to_back();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
